// File: rtl/prog_load_ctrl.sv
// Boot-time program loader: assembles a framed byte stream into imem lines and dmem words.
// Optional trailer checksum byte enabled by defining PLOAD_CHECKSUM_EN.
module prog_load_ctrl #(
   parameter int          IMEM_LINES = 512,
   parameter int          DMEM_WORDS = 4096,
   parameter logic [31:0] DMEM_BASE  = 32'h0
) (
   input  logic                          clk,
   input  logic                          reset_x,
   input  logic                          in_valid,
   input  logic [7:0]                    in_data,
   output logic                          in_ready,
   output logic                          core_reset,
   output logic                          loading,
   output logic                          done,
   output logic                          err,
   output logic                          imem_we,
   output logic [$clog2(IMEM_LINES)-1:0] imem_addr,
   output logic [127:0]                  imem_wdata,
   input  logic                          core_dmem_we,
   input  logic [31:0]                   core_dmem_addr,
   input  logic [31:0]                   core_dmem_wdata,
   output logic                          dmem_we,
   output logic [31:0]                   dmem_addr,
   output logic [31:0]                   dmem_wdata
);
   localparam int IAW = $clog2(IMEM_LINES);

   typedef enum logic [2:0] {
      S_HDR, S_IMEM, S_DMEM,
`ifdef PLOAD_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE, S_ERR
   } state_t;

`ifdef PLOAD_CHECKSUM_EN
   localparam state_t FIN_ST = S_CSUM;
`else
   localparam state_t FIN_ST = S_DONE;
`endif

   state_t         state_q, state_d;
   logic [127:0]   shift_q, shift_d;
   logic [3:0]     bcnt_q, bcnt_d;
   logic [15:0]    idx_q, idx_d, ni_q, ni_d, nd_q, nd_d;
   logic           rdy_q, rdy_d, crst_q;
   logic           iwe_q, iwe_d, dwe_q, dwe_d;
   logic [IAW-1:0] iaddr_q, iaddr_d;
   logic [31:0]    daddr_q, daddr_d;
   logic [31:0]    word;
   logic           acc, ld_sel;
`ifdef PLOAD_CHECKSUM_EN
   logic [7:0]     csum_q, csum_d;
`endif

   assign acc     = in_valid & rdy_q;
   assign shift_d = acc ? {in_data, shift_q[127:8]} : shift_q;
   assign word    = shift_d[127:96];

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      idx_d   = idx_q;
      ni_d    = ni_q;
      nd_d    = nd_q;
      iwe_d   = 1'b0;
      iaddr_d = iaddr_q;
      dwe_d   = 1'b0;
      daddr_d = daddr_q;
`ifdef PLOAD_CHECKSUM_EN
      csum_d  = acc ? (csum_q ^ in_data) : csum_q;
`endif
      if (acc) begin
         bcnt_d = bcnt_q + 4'd1;
         case (state_q)
            S_HDR: if (bcnt_q == 4'd3) begin
               bcnt_d = '0;
               ni_d   = word[15:0];
               nd_d   = word[31:16];
               if (32'(word[15:0]) > IMEM_LINES || 32'(word[31:16]) > DMEM_WORDS)
                  state_d = S_ERR;
               else if (word[15:0] != 16'd0)
                  state_d = S_IMEM;
               else if (word[31:16] != 16'd0)
                  state_d = S_DMEM;
               else
                  state_d = FIN_ST;
            end
            S_IMEM: if (bcnt_q == 4'd15) begin
               bcnt_d  = '0;
               iwe_d   = 1'b1;
               iaddr_d = idx_q[IAW-1:0];
               idx_d   = idx_q + 16'd1;
               if (idx_q == ni_q - 16'd1) begin
                  idx_d   = '0;
                  state_d = (nd_q != 16'd0) ? S_DMEM : FIN_ST;
               end
            end
            S_DMEM: if (bcnt_q == 4'd3) begin
               bcnt_d  = '0;
               dwe_d   = 1'b1;
               daddr_d = DMEM_BASE + {14'd0, idx_q, 2'b00};
               idx_d   = idx_q + 16'd1;
               if (idx_q == nd_q - 16'd1) begin
                  idx_d   = '0;
                  state_d = FIN_ST;
               end
            end
`ifdef PLOAD_CHECKSUM_EN
            // Trailer folds into the running XOR; a clean frame leaves zero.
            S_CSUM: state_d = (csum_d == 8'd0) ? S_DONE : S_ERR;
`endif
            default: ;
         endcase
      end
      rdy_d = (state_d != S_DONE) && (state_d != S_ERR);
   end

   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         state_q <= S_HDR;
         shift_q <= '0;
         bcnt_q  <= '0;
         idx_q   <= '0;
         ni_q    <= '0;
         nd_q    <= '0;
         rdy_q   <= 1'b0;
         crst_q  <= 1'b1;
         iwe_q   <= 1'b0;
         iaddr_q <= '0;
         dwe_q   <= 1'b0;
         daddr_q <= '0;
`ifdef PLOAD_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bcnt_q  <= bcnt_d;
         idx_q   <= idx_d;
         ni_q    <= ni_d;
         nd_q    <= nd_d;
         rdy_q   <= rdy_d;
         crst_q  <= (state_q != S_DONE);
         iwe_q   <= iwe_d;
         iaddr_q <= iaddr_d;
         dwe_q   <= dwe_d;
         daddr_q <= daddr_d;
`ifdef PLOAD_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign in_ready   = rdy_q;
   assign core_reset = crst_q;
   assign loading    = (state_q != S_DONE);
   assign done       = (state_q == S_DONE);
   assign err        = (state_q == S_ERR);
   assign imem_we    = iwe_q;
   assign imem_addr  = iaddr_q;
   assign imem_wdata = shift_q;

   // The final word strobe lands in the first DONE cycle, so keep the loader on the port for it.
   assign ld_sel     = loading | dwe_q;
   assign dmem_we    = ld_sel ? dwe_q           : core_dmem_we;
   assign dmem_addr  = ld_sel ? daddr_q         : core_dmem_addr;
   assign dmem_wdata = ld_sel ? shift_q[127:96] : core_dmem_wdata;
endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl; memory strobes checked against scoreboard queues by a monitor.
module tb_prog_load_ctrl;
   typedef logic [7:0] bq_t[$];

   logic         clk = 1'b0, reset_x = 1'b0, in_valid = 1'b0;
   logic [7:0]   in_data = '0;
   logic         in_ready, core_reset, loading, done, err, imem_we, dmem_we;
   logic [8:0]   imem_addr;
   logic [127:0] imem_wdata;
   logic         core_dmem_we = 1'b0;
   logic [31:0]  core_dmem_addr = '0, core_dmem_wdata = '0;
   logic [31:0]  dmem_addr, dmem_wdata;

   int errors = 0, checks = 0;
   logic [136:0] iq[$];
   logic [63:0]  dq[$];
   logic [136:0] ie;
   logic [63:0]  de;

   prog_load_ctrl dut (
      .clk(clk), .reset_x(reset_x), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .core_reset(core_reset), .loading(loading), .done(done),
      .err(err), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_dmem_we(core_dmem_we), .core_dmem_addr(core_dmem_addr),
      .core_dmem_wdata(core_dmem_wdata), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   // Memory-side monitor; while the core is out of reset dmem traffic belongs to the core.
   always @(negedge clk) begin
      if (reset_x === 1'b1 && imem_we === 1'b1) begin
         if (iq.size() == 0) fail("unexpected imem_we");
         else begin
            ie = iq.pop_front();
            check("imem_addr", 128'(imem_addr), 128'(ie[136:128]));
            check("imem_wdata", imem_wdata, ie[127:0]);
         end
      end
      if (reset_x === 1'b1 && dmem_we === 1'b1 && (loading === 1'b1 || core_reset === 1'b1)) begin
         if (dq.size() == 0) fail("unexpected loader dmem_we");
         else begin
            de = dq.pop_front();
            check("dmem_addr", 128'(dmem_addr), 128'(de[63:32]));
            check("dmem_wdata", 128'(dmem_wdata), 128'(de[31:0]));
         end
      end
   end

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         fail("send timeout");
         in_valid = 1'b0;
      end else @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_raw(input bq_t f);
      foreach (f[i]) send(f[i]);
   endtask

`ifdef PLOAD_CHECKSUM_EN
   function automatic logic [7:0] xsum(input bq_t f);
      logic [7:0] x;
      x = '0;
      foreach (f[i]) x ^= f[i];
      return x;
   endfunction
`endif

   task automatic send_frame(input bq_t f);
      bq_t g;
      g = f;
`ifdef PLOAD_CHECKSUM_EN
      g.push_back(xsum(f));
`endif
      send_raw(g);
      idle();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_x  = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      reset_x  = 1'b1;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (done !== 1'b1 && err !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check({name, " done"}, 128'(done), 128'd1);
      check({name, " core_reset held"}, 128'(core_reset), 128'd1);
      check({name, " loading"}, 128'(loading), 128'd0);
      @(negedge clk);
      check({name, " core_reset released"}, 128'(core_reset), 128'd0);
   endtask

   function automatic logic [6:0] outvec();
      return {in_ready, core_reset, loading, done, err, imem_we, dmem_we};
   endfunction

   initial begin
      bq_t f;
      bit ok;
      // Reset state and in_ready rising on the first edge after release
      #12;
      check("reset outputs", 128'(outvec()), 128'(7'b0110000));
      @(negedge clk);
      reset_x = 1'b1;
      @(posedge clk);
      #1;
      check("in_ready after release", 128'(in_ready), 128'd1);
      check("loader owns dmem in HDR", 128'({dmem_we, dmem_addr, dmem_wdata}), 128'd0);

      // One imem line, no dmem
      f = '{8'h01, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 16; i++) f.push_back(8'(i));
      iq.push_back({9'd0, 128'h0F0E0D0C0B0A09080706050403020100});
      send_frame(f);
      wait_done("imem1");

      // Core pass-through after load
      @(negedge clk);
      core_dmem_we = 1'b1; core_dmem_addr = 32'd8; core_dmem_wdata = 32'd5;
      #1;
      check("core passthru", 128'({dmem_we, dmem_addr, dmem_wdata}), 128'({1'b1, 32'd8, 32'd5}));
      core_dmem_we = 1'b0; core_dmem_addr = 32'd12; core_dmem_wdata = 32'h9;
      #1;
      check("core passthru 2", 128'({dmem_we, dmem_addr, dmem_wdata}), 128'({1'b0, 32'd12, 32'h9}));

      // Two dmem words with core inputs asserted throughout loading
      do_reset();
      core_dmem_we = 1'b1; core_dmem_addr = 32'd8; core_dmem_wdata = 32'd5;
      f = '{8'h00, 8'h00, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
      dq.push_back({32'h0, 32'hDEADBEEF});
      dq.push_back({32'h4, 32'h12345678});
      send_frame(f);
      wait_done("dmem2");
      core_dmem_we = 1'b0; core_dmem_addr = '0; core_dmem_wdata = '0;

      // Header bound errors
      do_reset();
      f = '{8'h01, 8'h02, 8'h00, 8'h00};
      send_raw(f);
      idle();
      check("N_I=513 err", 128'(err), 128'd1);
      check("N_I=513 in_ready", 128'(in_ready), 128'd0);
      ok = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (core_reset !== 1'b1 || err !== 1'b1 || done !== 1'b0) ok = 1'b0;
      end
      check("err holds core_reset 100 cycles", 128'(ok), 128'd1);

      do_reset();
      f = '{8'h00, 8'h00, 8'h01, 8'h10};
      send_raw(f);
      idle();
      check("N_D=4097 err", 128'(err), 128'd1);

      do_reset();
      f = '{8'h00, 8'h02, 8'h00, 8'h00};
      send_raw(f);
      idle();
      check("N_I=512 accepted", 128'({err, in_ready, loading}), 128'(3'b011));

      // Abort mid-line, then a fresh two-line plus one-word load
      do_reset();
      f = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
      send_raw(f);
      #2;
      reset_x  = 1'b0;
      in_valid = 1'b0;
      #1;
      check("async abort outputs", 128'(outvec()), 128'(7'b0110000));
      @(negedge clk);
      reset_x = 1'b1;
      f = '{8'h02, 8'h00, 8'h01, 8'h00};
      for (int i = 0; i < 16; i++) f.push_back(8'(i));
      for (int i = 0; i < 16; i++) f.push_back(8'(8'hA0 + i));
      f.push_back(8'h11); f.push_back(8'h22); f.push_back(8'h33); f.push_back(8'h44);
      iq.push_back({9'd0, 128'h0F0E0D0C0B0A09080706050403020100});
      iq.push_back({9'd1, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0});
      dq.push_back({32'h0, 32'h44332211});
      send_frame(f);
      wait_done("reload");

`ifdef PLOAD_CHECKSUM_EN
      do_reset();
      f = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
      dq.push_back({32'h0, 32'h00000001});
      send_raw(f);
      idle();
      wait_done("csum good");

      do_reset();
      f = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF};
      dq.push_back({32'h0, 32'h00000001});
      send_raw(f);
      idle();
      check("csum bad err", 128'({err, done}), 128'(2'b10));
`endif

      repeat (5) @(negedge clk);
      check("imem queue drained", 128'(iq.size()), 128'd0);
      check("dmem queue drained", 128'(dq.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
